tdm_demux4: RTL and testbench

- Receive end of the 4:1 mux path: rebuilds a 4-bit parallel word from a time-division serial stream.
- The stream is produced by a mux stepping its select 0,1,2,3.
- A frame marker `sync` identifies slot 0. A lock state machine tracks alignment, flags framing errors and emits one registered word per completed frame with a single-cycle `valid` pulse.

---
 rtl/tdm_demux4.sv | 102 ++++++++++
 tb/tb_tdm_demux4.sv | 112 +++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM link: realigns on the slot-0 marker, rebuilds
// the parallel word, and reports framing loss or early markers.
module tdm_demux4 #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          din,
  input  logic          sync,
  output logic [N-1:0]  o,
  output logic          valid,
  output logic [SW-1:0] slot,
  output logic          locked,
  output logic          sync_err
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [N-1:0]  shadow_q, shadow_d;
  logic [N-1:0]  o_q, o_d;
  logic          valid_q, valid_d;
  logic          locked_q, locked_d;
  logic          sync_err_q, sync_err_d;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    shadow_d   = shadow_q;
    o_d        = o_q;
    valid_d    = 1'b0;
    sync_err_d = 1'b0;

    if (en) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            shadow_d[0] = din;
            slot_d      = SW'(1);
            state_d     = LOCKED;
          end
        end
        default: begin
          if (slot_q == '0) begin
            if (sync) begin
              shadow_d[0] = din;
              slot_d      = SW'(1);
            end else begin
              sync_err_d = 1'b1;
              state_d    = HUNT;
              slot_d     = '0;
            end
          end else if (sync) begin
            // Early marker: drop the partial frame and restart at slot 1.
            sync_err_d  = 1'b1;
            shadow_d[0] = din;
            slot_d      = SW'(1);
          end else begin
            shadow_d[slot_q] = din;
            slot_d           = slot_q + SW'(1);
            if (slot_q == SW'(N-1)) begin
              o_d     = {din, shadow_q[N-2:0]};
              valid_d = 1'b1;
            end
          end
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      slot_q     <= '0;
      shadow_q   <= '0;
      o_q        <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      shadow_q   <= shadow_d;
      o_q        <= o_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign o        = o_q;
  assign valid    = valid_q;
  assign slot     = slot_q;
  assign locked   = locked_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: one step per clock, outputs checked 1 ns
// after the sampling edge against hand-computed values.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       sync = 1'b0;
  logic [3:0] o;
  logic       valid;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;

  int checks = 0;
  int errors = 0;

  tdm_demux4 #(.N(4), .SW(2)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync),
    .o(o), .valid(valid), .slot(slot), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic e, input logic s, input logic d);
    @(negedge clk);
    rst = r; en = e; sync = s; din = d;
    @(posedge clk);
    #1;
    $display("step rst=%0b en=%0b sync=%0b din=%0b -> o=%b valid=%0b slot=%0d locked=%0b sync_err=%0b",
             r, e, s, d, o, valid, slot, locked, sync_err);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Checks every output at once.
  task automatic chk_all(input string tag, input logic [3:0] eo, input logic ev,
                         input logic [1:0] es, input logic el, input logic ee);
    chk({tag, ".o"}, o, eo);
    chk({tag, ".valid"}, {3'b0, valid}, {3'b0, ev});
    chk({tag, ".slot"}, {2'b0, slot}, {2'b0, es});
    chk({tag, ".locked"}, {3'b0, locked}, {3'b0, el});
    chk({tag, ".sync_err"}, {3'b0, sync_err}, {3'b0, ee});
  endtask

  initial begin
    // Reset
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    chk_all("reset", 4'b0000, 0, 2'd0, 0, 0);

    // Frame 1001
    step(0, 1, 1, 1);  chk_all("f1.s0", 4'b0000, 0, 2'd1, 1, 0);
    step(0, 1, 0, 0);  chk_all("f1.s1", 4'b0000, 0, 2'd2, 1, 0);
    step(0, 1, 0, 0);  chk_all("f1.s2", 4'b0000, 0, 2'd3, 1, 0);
    step(0, 1, 0, 1);  chk_all("f1.s3", 4'b1001, 1, 2'd0, 1, 0);

    // Back-to-back frame 0110
    step(0, 1, 1, 0);  chk_all("f2.s0", 4'b1001, 0, 2'd1, 1, 0);
    step(0, 1, 0, 1);  chk_all("f2.s1", 4'b1001, 0, 2'd2, 1, 0);
    step(0, 1, 0, 1);  chk_all("f2.s2", 4'b1001, 0, 2'd3, 1, 0);
    step(0, 1, 0, 0);  chk_all("f2.s3", 4'b0110, 1, 2'd0, 1, 0);

    // Missing marker at slot 0
    step(0, 1, 0, 1);  chk_all("miss", 4'b0110, 0, 2'd0, 0, 1);
    step(0, 1, 0, 0);  chk_all("hunt1", 4'b0110, 0, 2'd0, 0, 0);
    step(0, 1, 0, 1);  chk_all("hunt2", 4'b0110, 0, 2'd0, 0, 0);
    step(0, 1, 0, 1);  chk_all("hunt3", 4'b0110, 0, 2'd0, 0, 0);

    // Frame 1111 from HUNT
    step(0, 1, 1, 1);  chk_all("f3.s0", 4'b0110, 0, 2'd1, 1, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);  chk_all("f3.s3", 4'b1111, 1, 2'd0, 1, 0);

    // Early marker at slot 2, then realigned frame 0,0,1,1
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);  chk_all("f4.s1", 4'b1111, 0, 2'd2, 1, 0);
    step(0, 1, 1, 0);  chk_all("early", 4'b1111, 0, 2'd1, 1, 1);
    step(0, 1, 0, 0);  chk_all("f5.s1", 4'b1111, 0, 2'd2, 1, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);  chk_all("f5.s3", 4'b1100, 1, 2'd0, 1, 0);

    // Frame 1010 with en gaps carrying misleading sync/din
    step(0, 1, 1, 0);  chk_all("f6.s0", 4'b1100, 0, 2'd1, 1, 0);
    step(0, 0, 1, 0);  chk_all("f6.g0", 4'b1100, 0, 2'd1, 1, 0);
    step(0, 1, 0, 1);
    step(0, 0, 1, 1);  chk_all("f6.g1", 4'b1100, 0, 2'd2, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);  chk_all("f6.g2", 4'b1100, 0, 2'd3, 1, 0);
    step(0, 1, 0, 1);  chk_all("f6.s3", 4'b1010, 1, 2'd0, 1, 0);
    step(0, 0, 1, 1);  chk_all("f6.g3", 4'b1010, 0, 2'd0, 1, 0);

    // Reset mid-frame, then no sync: must stay hunting
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);  chk_all("f7.s1", 4'b1010, 0, 2'd2, 1, 0);
    step(1, 1, 0, 1);  chk_all("midrst", 4'b0000, 0, 2'd0, 0, 0);
    step(0, 1, 0, 1);  chk_all("post.h0", 4'b0000, 0, 2'd0, 0, 0);
    step(0, 1, 0, 1);  chk_all("post.h1", 4'b0000, 0, 2'd0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
